// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared image geometry and loader state encoding
package cnn_pkg;

    localparam int IMG_BITS  = 784;
    localparam int IMG_BYTES = IMG_BITS / 8;
    localparam int ADDR_W    = 10;
    localparam int CNT_W     = $clog2(IMG_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        START,
        RUN
    } ld_state_t;

endpackage

// File: rtl/img_loader.sv
// rtl/img_loader.sv - unpacks received bytes into 1-bit pixels for the CNN input RAM
module img_loader
    import cnn_pkg::*;
(
    input  logic              clk,
    input  logic              RST_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_rdy,
    input  logic              core_done,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic              wdata,
    output logic              start,
    output logic              busy,
    output logic              ovr
);

    ld_state_t         state, state_nx;
    logic [7:0]        sr, sr_nx;
    logic [7:0]        hold, hold_nx;
    logic              hold_valid, hold_valid_nx;
    logic [CNT_W-1:0]  byte_cnt, byte_cnt_nx;
    logic [2:0]        bit_cnt, bit_cnt_nx;
    logic              we_nx, wdata_nx, start_nx, busy_nx, ovr_nx;
    logic [ADDR_W-1:0] waddr_nx;
    logic              last_byte;

    assign last_byte = (byte_cnt == CNT_W'(IMG_BYTES - 1));

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state      <= IDLE;
            sr         <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
            byte_cnt   <= '0;
            bit_cnt    <= '0;
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= 1'b0;
            start      <= 1'b0;
            busy       <= 1'b0;
            ovr        <= 1'b0;
        end else begin
            state      <= state_nx;
            sr         <= sr_nx;
            hold       <= hold_nx;
            hold_valid <= hold_valid_nx;
            byte_cnt   <= byte_cnt_nx;
            bit_cnt    <= bit_cnt_nx;
            we         <= we_nx;
            waddr      <= waddr_nx;
            wdata      <= wdata_nx;
            start      <= start_nx;
            busy       <= busy_nx;
            ovr        <= ovr_nx;
        end
    end

    // bit_cnt is the index k of the pixel currently on the write port
    always_comb begin
        state_nx      = state;
        sr_nx         = sr;
        hold_nx       = hold;
        hold_valid_nx = hold_valid;
        byte_cnt_nx   = byte_cnt;
        bit_cnt_nx    = bit_cnt;
        we_nx         = 1'b0;
        waddr_nx      = waddr;
        wdata_nx      = wdata;
        start_nx      = 1'b0;
        busy_nx       = busy;
        ovr_nx        = ovr;

        case (state)
            IDLE: begin
                if (rx_rdy) begin
                    state_nx   = SHIFT;
                    sr_nx      = rx_data;
                    bit_cnt_nx = '0;
                    we_nx      = 1'b1;
                    waddr_nx   = ADDR_W'({byte_cnt, 3'b000});
                    wdata_nx   = rx_data[0];
                end
            end

            SHIFT: begin
                if (bit_cnt != 3'd7) begin
                    bit_cnt_nx = bit_cnt + 3'd1;
                    we_nx      = 1'b1;
                    waddr_nx   = waddr + 1'b1;
                    wdata_nx   = sr[bit_cnt + 3'd1];
                    if (rx_rdy) begin
                        if (!hold_valid) begin
                            hold_nx       = rx_data;
                            hold_valid_nx = 1'b1;
                        end else begin
                            ovr_nx = 1'b1;
                        end
                    end
                end else if (last_byte) begin
                    // image complete: anything still arriving is a 99th byte
                    state_nx      = START;
                    byte_cnt_nx   = '0;
                    start_nx      = 1'b1;
                    busy_nx       = 1'b1;
                    hold_valid_nx = 1'b0;
                    if (hold_valid || rx_rdy) begin
                        ovr_nx = 1'b1;
                    end
                end else begin
                    byte_cnt_nx = byte_cnt + 1'b1;
                    bit_cnt_nx  = '0;
                    if (hold_valid) begin
                        sr_nx         = hold;
                        we_nx         = 1'b1;
                        waddr_nx      = waddr + 1'b1;
                        wdata_nx      = hold[0];
                        hold_valid_nx = rx_rdy;
                        if (rx_rdy) begin
                            hold_nx = rx_data;
                        end
                    end else if (rx_rdy) begin
                        sr_nx    = rx_data;
                        we_nx    = 1'b1;
                        waddr_nx = waddr + 1'b1;
                        wdata_nx = rx_data[0];
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end

            START: begin
                state_nx = RUN;
                busy_nx  = 1'b1;
                if (rx_rdy) begin
                    ovr_nx = 1'b1;
                end
            end

            RUN: begin
                if (rx_rdy) begin
                    ovr_nx = 1'b1;
                end
                if (core_done) begin
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: doc/img_loader.md
Name: img_loader

Overview:
Front-end stage between the UART receiver and the CNN core. It takes image bytes from the receiver (rx_data/rx_rdy), unpacks each byte into 8 one-bit pixels, and writes them serially into the 784x1 input RAM. After the 98th byte it issues a one-cycle start to the core, then ignores input until the core reports done.

Parameters:
IMG_BITS, 784, pixels per image (1 bit each)
IMG_BYTES, IMG_BITS/8 = 98, bytes per image
ADDR_W, 10, input RAM address width

Ports:
clk  in  1  system clock
RST_n  in  1  reset, asynchronous, active-low
rx_data  in  8  received byte; valid only when rx_rdy=1
rx_rdy  in  1  one-cycle strobe: rx_data is valid
core_done  in  1  one-cycle pulse from core: inference finished
we  out  1  input RAM write enable
waddr  out  ADDR_W  input RAM write address, 0..783
wdata  out  1  input RAM write data (pixel bit)
start  out  1  one-cycle pulse: image complete, core may run
busy  out  1  high from START through RUN, until core_done
ovr  out  1  sticky overrun/drop flag; cleared only by reset

Behaviour:
- All outputs are registered. Reset values: we=0, waddr=0, wdata=0, start=0, busy=0, ovr=0. Internal state on reset: byte_cnt=0, bit_cnt=0, hold_valid=0, state=IDLE.
- Bit order: pixel index = byte_cnt*8 + k, where wdata = rx_data[k] and k runs 0..7 (LSB first).
- IDLE: rx_rdy at edge N captures rx_data into sr and moves to SHIFT. we=1 on cycles N+1..N+8, with waddr = byte_cnt*8+k and wdata = sr[k].
- SHIFT, on the cycle with k=7:
  - If hold_valid=1, load hold into sr, clear hold_valid, stay in SHIFT. The next byte's writes follow contiguously (no gap).
  - Else if rx_rdy=1 on that same edge, load rx_data directly into sr and stay in SHIFT.
  - Else, if byte_cnt < IMG_BYTES-1, go to IDLE.
  - byte_cnt increments at the end of every byte.
- After the byte with byte_cnt = IMG_BYTES-1 finishes: go to START. byte_cnt becomes 0; any pending hold is discarded and sets ovr (a 99th byte).
- rx_rdy during SHIFT, other than the k=7 direct-load case:
  - hold_valid=0: store the byte in hold, set hold_valid.
  - hold_valid=1: drop the byte, set ovr.
- If rx_rdy and the k=7 hold-load happen together, hold reloads with the new byte.
- START: start=1 and busy=1 for exactly one cycle. start rises on the cycle after the last we. Then go to RUN.
- RUN: busy=1 until core_done is seen, then busy=0 and return to IDLE on the next cycle.
- rx_rdy while in START or RUN: byte dropped, no write, ovr set.
- core_done in IDLE or SHIFT: ignored.
- Reset mid-image (RST_n low at any time): all state clears asynchronously and the partial image is abandoned. The next byte after reset is pixel 0..7.
- Latency: rx_rdy to first write is 1 cycle; last rx_rdy to start is 9 cycles when the loader is otherwise idle.
- Throughput: 1 byte per 8 cycles sustained; burst tolerance is 2 back-to-back bytes.

Decomposition:
- Shared package cnn_pkg holds: IMG_BITS, IMG_BYTES, ADDR_W, and the state enum typedef ld_state_t {IDLE, SHIFT, START, RUN}.
- A single flat module; no sub-module is warranted. The holding register is ~10 lines of logic and is not worth splitting out.

Test Plan:
- 98 bytes, one every 51 cycles, from a random 784-bit vector -> exactly 784 we pulses; RAM model equals the vector bit-for-bit with LSB-first order; one start pulse 9 cycles after the last rx_rdy; busy=1 until core_done.
- Byte 8'hA5 as byte 0 -> writes at addresses 0..7 with data 1,0,1,0,0,1,0,1 on consecutive cycles.
- Two rx_rdy on consecutive cycles (0xFF, 0x00) -> 16 contiguous we cycles, addresses 0..15, data eight 1s then eight 0s; ovr stays 0.
- Three rx_rdy on consecutive cycles -> third byte dropped, ovr=1, only 16 writes.
- After start, send a byte during RUN -> no we, ovr=1; pulse core_done -> busy=0; the next full image loads normally starting at address 0.
- Pull RST_n low after 40 bytes -> all outputs 0 immediately. After release, a full 98-byte image produces start and RAM holds only the new image.
